// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul datapath: dot-product FSM states,
// accumulator sizing and signed saturation.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } dp_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_VEC_LEN    = 8;
  localparam int unsigned SAT_W          = 128;

  // Accumulator wide enough that VEC_LEN full-scale products never overflow.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned vl);
    return 2 * dw + $clog2(vl) + 1;
  endfunction

  localparam int unsigned ACC_WIDTH = acc_width(DEF_DATA_WIDTH, DEF_VEC_LEN);

  // Clamp a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_to_width(input logic signed [SAT_W-1:0] value,
                                                           input int unsigned width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
    lo = -hi - SAT_W'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/dp_mac_pipe.sv
// Multiply-accumulate pipeline: data-valid stage, product register, accumulator
// and saturated result write on the final element.
module dp_mac_pipe
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned VEC_LEN    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic                      last,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     wt,
  input  logic [DATA_WIDTH-1:0]     act,
  output logic [2*DATA_WIDTH-1:0]   result,
  output logic                      done,
  output logic                      final_c
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, VEC_LEN);

  logic                     s1_valid;
  logic                     s1_last;
  logic                     s2_valid;
  logic                     s2_last;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum_c;

  assign acc_sum_c = acc + ACC_W'(prod);
  assign final_c   = s2_valid & s2_last;

  // s1: read data on the bus, s2: product registered, then accumulate/write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      prod     <= '0;
      acc      <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      s1_valid <= valid;
      s1_last  <= valid & last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) prod <= PROD_W'($signed(wt)) * PROD_W'($signed(act));
      done <= final_c;
      if (clear) begin
        acc <= '0;
      end else if (s2_valid) begin
        acc <= final_c ? '0 : acc_sum_c;
      end
      if (final_c) result <= PROD_W'(sat_to_width(SAT_W'(acc_sum_c), PROD_W));
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Signed dot product of one weight row against the input vector; owns the
// IDLE/FETCH/DRAIN sequencing and read-address generation.
module dot_product_engine
  import matmul_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 10,
  parameter int unsigned           DATA_WIDTH   = 16,
  parameter int unsigned           VEC_LEN      = 8,
  parameter logic [ADDR_WIDTH-1:0] IN_BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    done,
  input  logic [ADDR_WIDTH-1:0]   weight_base_addr,
  output logic [2*DATA_WIDTH-1:0] result,
  output logic                    busy,
  output logic                    wt_rd_en,
  output logic [ADDR_WIDTH-1:0]   wt_rd_addr,
  input  logic [DATA_WIDTH-1:0]   wt_rd_data,
  output logic                    in_rd_en,
  output logic [ADDR_WIDTH-1:0]   in_rd_addr,
  input  logic [DATA_WIDTH-1:0]   in_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LEN - 1);

  dp_state_t             state;
  dp_state_t             state_n;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] idx_n;
  logic [ADDR_WIDTH-1:0] wt_addr_n;
  logic [ADDR_WIDTH-1:0] in_addr_n;
  logic                  rd_en_n;
  logic                  rd_last;
  logic                  rd_last_n;
  logic                  busy_n;
  logic                  accept_c;
  logic                  final_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      wt_rd_en   <= 1'b0;
      in_rd_en   <= 1'b0;
      wt_rd_addr <= '0;
      in_rd_addr <= '0;
      rd_last    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      wt_rd_en   <= rd_en_n;
      in_rd_en   <= rd_en_n;
      wt_rd_addr <= wt_addr_n;
      in_rd_addr <= in_addr_n;
      rd_last    <= rd_last_n;
      busy       <= busy_n;
    end
  end

  // Addresses advance incrementally so base+idx wraps at ADDR_WIDTH for free.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wt_addr_n = wt_rd_addr;
    in_addr_n = in_rd_addr;
    rd_en_n   = 1'b0;
    rd_last_n = 1'b0;
    busy_n    = busy;
    accept_c  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = start;
        if (start) begin
          accept_c  = 1'b1;
          state_n   = FETCH;
          idx_n     = '0;
          wt_addr_n = weight_base_addr;
          in_addr_n = IN_BASE_ADDR;
          rd_en_n   = 1'b1;
          rd_last_n = (LAST_IDX == '0);
        end
      end
      FETCH: begin
        busy_n = 1'b1;
        if (idx == LAST_IDX) begin
          state_n = DRAIN;
        end else begin
          idx_n     = idx + ADDR_WIDTH'(1);
          wt_addr_n = wt_rd_addr + ADDR_WIDTH'(1);
          in_addr_n = in_rd_addr + ADDR_WIDTH'(1);
          rd_en_n   = 1'b1;
          rd_last_n = ((idx + ADDR_WIDTH'(1)) == LAST_IDX);
        end
      end
      DRAIN: begin
        busy_n = 1'b1;
        // Leave on the edge that writes the result so start can land in the done cycle.
        if (final_c) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  dp_mac_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .VEC_LEN   (VEC_LEN)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .valid  (wt_rd_en),
    .last   (rd_last),
    .clear  (accept_c),
    .wt     (wt_rd_data),
    .act    (in_rd_data),
    .result (result),
    .done   (done),
    .final_c(final_c)
  );

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: memory models, a cycle-level reference of the
// strobe/busy/done timing, and a result scoreboard.
module tb_dot_product_engine;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned RW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic [AW-1:0] weight_base_addr = '0;
  logic [RW-1:0] result;
  logic          busy;
  logic          wt_rd_en;
  logic [AW-1:0] wt_rd_addr;
  logic [DW-1:0] wt_rd_data = '0;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic [DW-1:0] in_rd_data = '0;

  always #5 clk = ~clk;

  dot_product_engine #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .VEC_LEN     (N),
    .IN_BASE_ADDR(10'd0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .done            (done),
    .weight_base_addr(weight_base_addr),
    .result          (result),
    .busy            (busy),
    .wt_rd_en        (wt_rd_en),
    .wt_rd_addr      (wt_rd_addr),
    .wt_rd_data      (wt_rd_data),
    .in_rd_en        (in_rd_en),
    .in_rd_addr      (in_rd_addr),
    .in_rd_data      (in_rd_data)
  );

  logic [DW-1:0] wt_mem [1024];
  logic [DW-1:0] in_mem [1024];

  // Synchronous 1-cycle read ports; junk on the bus when not strobed.
  always @(posedge clk) begin
    wt_rd_data <= wt_rd_en ? wt_mem[wt_rd_addr] : DW'($urandom);
    in_rd_data <= in_rd_en ? in_mem[in_rd_addr] : DW'($urandom);
  end

  // Reference timing model and scoreboard.
  int            checks = 0;
  int            errors = 0;
  longint        run_exp = 0;
  bit            model_idle = 1'b1;
  int            pos_cnt = 0;
  int            acc_cnt = 0;
  int            j;
  bit            pre_idle;
  bit            accepted;
  logic [AW-1:0] run_base = '0;
  bit            exp_done = 1'b0;
  bit            exp_busy = 1'b0;
  bit            exp_strobe = 1'b0;
  logic [AW-1:0] exp_wt_addr = '0;
  logic [AW-1:0] exp_in_addr = '0;
  logic [RW-1:0] exp_result = '0;
  logic [RW-1:0] sb [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_idle = 1'b1;
      exp_done   = 1'b0;
      exp_busy   = 1'b0;
      exp_strobe = 1'b0;
      exp_result = '0;
      sb.delete();
    end else begin
      pos_cnt  = pos_cnt + 1;
      pre_idle = model_idle;
      accepted = start && pre_idle;
      if (accepted) begin
        acc_cnt    = pos_cnt;
        run_base   = weight_base_addr;
        model_idle = 1'b0;
        sb.push_back(RW'(run_exp));
      end else if (!pre_idle && pos_cnt == acc_cnt + int'(N) + 2) begin
        model_idle = 1'b1;
      end
      exp_done = !pre_idle && (pos_cnt == acc_cnt + int'(N) + 2);
      if (exp_done && sb.size() > 0) exp_result = sb.pop_front();
      exp_busy    = accepted || !pre_idle;
      j           = pos_cnt - acc_cnt;
      exp_strobe  = exp_busy && (j < int'(N));
      exp_wt_addr = AW'(int'(run_base) + j);
      exp_in_addr = AW'(j);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      #1;
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wt_en", 64'(wt_rd_en), 64'd0);
      chk("rst_in_en", 64'(in_rd_en), 64'd0);
      chk("rst_wt_addr", 64'(wt_rd_addr), 64'd0);
      chk("rst_in_addr", 64'(in_rd_addr), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
    end else begin
      chk("done", 64'(done), 64'(exp_done));
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("wt_rd_en", 64'(wt_rd_en), 64'(exp_strobe));
      chk("in_rd_en", 64'(in_rd_en), 64'(exp_strobe));
      if (exp_strobe) begin
        chk("wt_rd_addr", 64'(wt_rd_addr), 64'(exp_wt_addr));
        chk("in_rd_addr", 64'(in_rd_addr), 64'(exp_in_addr));
      end
      chk(done ? "result" : "result_hold", 64'(result), 64'(exp_result));
    end
  end

  typedef struct {
    logic [AW-1:0] base;
    int            w0;
    int            ws;
    int            i0;
    int            is;
    longint        exp;
  } vec_t;

  vec_t vecs [6];

  task automatic load(input logic [AW-1:0] base, input int w0, input int ws, input int i0,
                      input int is);
    for (int i = 0; i < int'(N); i++) begin
      wt_mem[AW'(int'(base) + i)] = DW'(w0 + i * ws);
      in_mem[i]                   = DW'(i0 + i * is);
    end
  endtask

  task automatic launch(input logic [AW-1:0] base);
    @(negedge clk);
    weight_base_addr = base;
    start            = 1'b1;
    @(negedge clk);
    start            = 1'b0;
    weight_base_addr = AW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      wt_mem[i] = '0;
      in_mem[i] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    vecs[0] = '{10'd0,    1,      1,     1,      0, 64'sd36};
    vecs[1] = '{10'd16,   -3,     0,     2,      1, -64'sd132};
    vecs[2] = '{10'd100,  -32768, 0,     -32768, 0, 64'sd2147483647};
    vecs[3] = '{10'd200,  -32768, 0,     32767,  0, -64'sd2147483648};
    vecs[4] = '{10'd1020, 5,      -2,    1,      1, -64'sd156};
    vecs[5] = '{10'd50,   1000,   1000,  30000,  0, 64'sd1080000000};

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].base, vecs[v].w0, vecs[v].ws, vecs[v].i0, vecs[v].is);
      run_exp = vecs[v].exp;
      launch(vecs[v].base);
      repeat (N + 4) @(negedge clk);
    end

    // start re-pulsed mid-run with another base must be ignored
    load(10'd300, 7, 0, 1, 0);
    load(10'd0, 1, 1, 1, 0);
    run_exp = 36;
    launch(10'd0);
    repeat (2) @(negedge clk);
    weight_base_addr = 10'd300;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);

    // start held through done: second run follows with no idle cycle
    weight_base_addr = 10'd0;
    start            = 1'b1;
    repeat (N + 4) @(negedge clk);
    start = 1'b0;
    repeat (N + 6) @(negedge clk);

    // reset mid-run, then a clean run must show no residue
    launch(10'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    load(10'd16, -3, 0, 2, 1);
    run_exp = -132;
    launch(10'd16);
    repeat (N + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
